// File: rtl/align_rr_arbiter.sv
// ---------------------------------------------------------------------------
// align_rr_arbiter
//
// Purpose:
//   Shares one sign-alignment datapath between N_REQ partial-product lanes.
//   Each lane offers {sign, PP_W-bit unsigned shifted pp}. The granted lane's
//   pp is converted into an OUT_W-bit two's-complement aligned value and
//   captured in a single registered output slot with a valid/ready handshake.
//   This block sits between the per-lane multiplier shift stages and the MAC
//   adder tree.
//
// Configuration macro:
//   ALIGN_ARB_FIXED_PRIO_EN
//     Defined:   fixed priority, lane 0 highest. There is no rotating
//                pointer, so high-index lanes may starve.
//     Undefined: round-robin grant from a rotating pointer (default).
//
// Ports:
//   i_clk        in   1            clock, rising edge
//   i_rst_n      in   1            asynchronous active-low reset
//   i_req_valid  in   N_REQ        per-lane request valid
//   i_req_pp     in   N_REQ*PP_W   per-lane unsigned pp, lane k at [k*PP_W +: PP_W]
//   i_req_sign   in   N_REQ        per-lane pp sign (1 = negative)
//   o_req_ready  out  N_REQ        one-hot accept to the granted lane (combinational)
//   o_valid      out  1            output slot holds a result
//   i_ready      in   1            downstream accepts the result
//   o_align_pp   out  OUT_W        aligned two's-complement pp
//   o_src_id     out  ID_W         lane index that produced o_align_pp
//   number       out  51           constant gate-count estimate of the block
// ---------------------------------------------------------------------------
module align_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PP_W  = 14,
    parameter int OUT_W = PP_W + 1,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*PP_W-1:0]   i_req_pp,
    input  logic [N_REQ-1:0]        i_req_sign,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [OUT_W-1:0] o_align_pp,
    output logic [ID_W-1:0]         o_src_id,
    output logic [50:0]             number
);

    // Gate-count contributions of the datapath primitives and the control.
    localparam int INV_GATES = OUT_W;          // one inverter per bit
    localparam int ADD_GATES = 5 * OUT_W;      // ripple full adder per bit
    localparam int MX_GATES  = 3 * OUT_W;      // 2:1 mux per bit
    localparam int ARB_GATES = N_REQ * (ID_W + 2);
`ifdef ALIGN_ARB_FIXED_PRIO_EN
    localparam int PTR_REGS  = 0;
`else
    localparam int PTR_REGS  = ID_W;
`endif
    localparam int REG_GATES = OUT_W + ID_W + 2 + PTR_REGS;
    localparam int TOTAL_GATES = INV_GATES + ADD_GATES + MX_GATES
                               + ARB_GATES + REG_GATES;

    // -----------------------------------------------------------------------
    // Datapath primitives
    // -----------------------------------------------------------------------
    function automatic logic [OUT_W-1:0] prim_inv(input logic [OUT_W-1:0] a);
        return ~a;
    endfunction

    function automatic logic [OUT_W-1:0] prim_add(input logic [OUT_W-1:0] a,
                                                  input logic [OUT_W-1:0] b);
        // Carry-out is intentionally discarded.
        return a + b;
    endfunction

    function automatic logic [OUT_W-1:0] prim_mx(input logic             s,
                                                 input logic [OUT_W-1:0] a0,
                                                 input logic [OUT_W-1:0] a1);
        return s ? a1 : a0;
    endfunction

    // Zero-extend pp by one bit, then negate via invert+1 when sign is set.
    // The extra bit guarantees the negation of the largest pp cannot overflow,
    // and a negative zero wraps back to zero through the discarded carry.
    function automatic logic signed [OUT_W-1:0] align_value(input logic            sign,
                                                            input logic [PP_W-1:0] pp);
        logic [OUT_W-1:0] ext;
        logic [OUT_W-1:0] neg;
        ext = {1'b0, pp};
        neg = prim_add(prim_inv(ext), OUT_W'(1));
        return $signed(prim_mx(sign, ext, neg));
    endfunction

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    slot_state_t             state_p1;
    logic                    vld_p1;
    logic signed [OUT_W-1:0] align_pp_p1;
    logic [ID_W-1:0]         src_id_p1;

    logic                    any_valid;
    logic [ID_W-1:0]         grant_id;
    logic                    can_accept;
    logic                    xfer;
    logic [PP_W-1:0]         sel_pp;
    logic                    sel_sign;
    logic signed [OUT_W-1:0] align_pp_p0;

    // -----------------------------------------------------------------------
    // Stage p0: grant selection and alignment of the granted lane
    // -----------------------------------------------------------------------
`ifdef ALIGN_ARB_FIXED_PRIO_EN
    // Scan from the highest lane down so the lowest-index valid lane wins.
    always_comb begin
        any_valid = 1'b0;
        grant_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                any_valid = 1'b1;
                grant_id  = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W:0]   scan_idx;

    // Walk lane offsets from farthest to nearest so that the last match,
    // which wins, is the first valid lane at or after the pointer.
    always_comb begin
        any_valid = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (scan_idx >= (ID_W + 1)'(N_REQ)) begin
                scan_idx = scan_idx - (ID_W + 1)'(N_REQ);
            end
            if (i_req_valid[scan_idx[ID_W-1:0]]) begin
                any_valid = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            if (grant_id == ID_W'(N_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id + ID_W'(1);
            end
        end
    end
`endif

    assign can_accept  = !vld_p1 || i_ready;
    assign xfer        = any_valid && can_accept;
    assign o_req_ready = xfer ? (N_REQ'(1) << grant_id) : '0;

    assign sel_pp      = i_req_pp[int'(grant_id) * PP_W +: PP_W];
    assign sel_sign    = i_req_sign[grant_id];
    assign align_pp_p0 = align_value(sel_sign, sel_pp);

    // -----------------------------------------------------------------------
    // Stage p1: output slot
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_p1    <= S_EMPTY;
            vld_p1      <= 1'b0;
            align_pp_p1 <= '0;
            src_id_p1   <= '0;
        end else begin
            case (state_p1)
                S_EMPTY: begin
                    if (xfer) begin
                        state_p1    <= S_FULL;
                        vld_p1      <= 1'b1;
                        align_pp_p1 <= align_pp_p0;
                        src_id_p1   <= grant_id;
                    end
                end
                S_FULL: begin
                    if (xfer) begin
                        // Downstream took the old result; refill without a bubble.
                        align_pp_p1 <= align_pp_p0;
                        src_id_p1   <= grant_id;
                    end else if (i_ready) begin
                        state_p1 <= S_EMPTY;
                        vld_p1   <= 1'b0;
                    end
                end
                default: begin
                    state_p1 <= S_EMPTY;
                    vld_p1   <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid    = vld_p1;
    assign o_align_pp = align_pp_p1;
    assign o_src_id   = src_id_p1;
    assign number     = 51'(TOTAL_GATES);

endmodule

// File: tb/tb_align_rr_arbiter.sv
module tb_align_rr_arbiter;

    localparam int N     = 4;
    localparam int PP_W  = 14;
    localparam int OUT_W = PP_W + 1;
    localparam int ID_W  = 2;
`ifdef ALIGN_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*PP_W-1:0] req_pp;
    logic [N-1:0]      req_sign;
    logic [N-1:0]      req_ready;
    logic              o_valid;
    logic              ready;
    logic [OUT_W-1:0]  align_pp;
    logic [ID_W-1:0]   src_id;
    logic [50:0]       number_w;

    int n_tests = 0;
    int n_fail  = 0;

    align_rr_arbiter #(.N_REQ(N), .PP_W(PP_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_pp    (req_pp),
        .i_req_sign  (req_sign),
        .o_req_ready (req_ready),
        .o_valid     (o_valid),
        .i_ready     (ready),
        .o_align_pp  (align_pp),
        .o_src_id    (src_id),
        .number      (number_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_lane(input int k, input logic v, input logic [PP_W-1:0] pp, input logic s);
        req_valid[k]            = v;
        req_pp[k*PP_W +: PP_W]  = pp;
        req_sign[k]             = s;
    endtask

    task automatic idle();
        req_valid = '0;
        req_pp    = '0;
        req_sign  = '0;
        ready     = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural alignment: sign ? (2^OUT_W - pp) mod 2^OUT_W : pp
    function automatic logic [OUT_W-1:0] ref_align(input logic s, input logic [PP_W-1:0] pp);
        int v;
        v = s ? ((1 << OUT_W) - int'(pp)) % (1 << OUT_W) : int'(pp);
        return OUT_W'(v);
    endfunction

    typedef struct {
        int               lane;
        logic [PP_W-1:0]  pp;
        logic             sign;
        logic [OUT_W-1:0] exp_pp;
    } vec_t;

    vec_t vecs[8];

    // Random-test model state
    bit               pres[N];
    logic [PP_W-1:0]  cur_pp[N];
    logic             cur_sign[N];
    bit               m_full;
    int               m_ptr;
    int               m_src;
    logic [OUT_W-1:0] m_pp;
    int               grant;
    logic [N-1:0]     exp_rdy;

    initial begin
        vecs[0] = '{1, 14'h0005, 1'b1, 15'h7FFB};
        vecs[1] = '{0, 14'h0000, 1'b1, 15'h0000};
        vecs[2] = '{2, 14'h3FFF, 1'b1, 15'h4001};
        vecs[3] = '{3, 14'h3FFF, 1'b0, 15'h3FFF};
        vecs[4] = '{1, 14'h0001, 1'b1, 15'h7FFF};
        vecs[5] = '{2, 14'h2000, 1'b1, 15'h6000};
        vecs[6] = '{0, 14'h1234, 1'b0, 15'h1234};
        vecs[7] = '{3, 14'h1234, 1'b1, 15'h6DCC};

        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_valid", o_valid, 0);
        check("rst_pp", align_pp, 0);
        check("rst_src", src_id, 0);
        check("rst_req_ready", req_ready, 0);
        n_tests++;
        if (number_w == '0) begin
            n_fail++;
            $display("FAIL number: got 0, expected a nonzero gate count");
        end
        rst_n = 1'b1;

        // Table-driven single-lane alignment vectors
        for (int v = 0; v < 8; v++) begin
            idle();
            set_lane(vecs[v].lane, 1'b1, vecs[v].pp, vecs[v].sign);
            #1;
            check("tbl_req_ready", req_ready, N'(1) << vecs[v].lane);
            @(negedge clk);
            check("tbl_valid", o_valid, 1);
            check("tbl_pp", align_pp, vecs[v].exp_pp);
            check("tbl_src", src_id, vecs[v].lane);
        end
        idle();
        @(negedge clk);
        check("drain_valid", o_valid, 0);

        // All lanes valid continuously: rotation with no bubbles
        do_reset();
        for (int k = 0; k < N; k++) set_lane(k, 1'b1, PP_W'(k + 1), 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rr_valid", o_valid, 1);
            check("rr_src", src_id, FIXED ? 0 : c % N);
            check("rr_pp", align_pp, FIXED ? 1 : (c % N) + 1);
        end

        // Backpressure for 3 cycles while FULL
        ready = 1'b0;
        #1;
        check("bp_req_ready", req_ready, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_valid", o_valid, 1);
            check("bp_src", src_id, 0);
            check("bp_pp", align_pp, 1);
            check("bp_req_ready_hold", req_ready, 0);
        end
        ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, FIXED ? 4'b0001 : 4'b0010);
        @(negedge clk);
        check("bp_release_src", src_id, FIXED ? 0 : 1);

        // Asynchronous reset while FULL, checked before the next clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", o_valid, 0);
        check("async_rst_pp", align_pp, 0);
        check("async_rst_src", src_id, 0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;

        // Lanes 0 and 2 always valid
        set_lane(0, 1'b1, 14'h0010, 1'b0);
        set_lane(2, 1'b1, 14'h0020, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("l02_src", src_id, FIXED ? 0 : ((c % 2) ? 2 : 0));
            check("l02_pp", align_pp, FIXED ? 15'h0010 : ((c % 2) ? 15'h7FE0 : 15'h0010));
        end

        // Randomized traffic against a behavioural model
        do_reset();
        m_full = 0;
        m_ptr  = 0;
        m_src  = 0;
        m_pp   = '0;
        for (int k = 0; k < N; k++) begin
            pres[k]     = 0;
            cur_pp[k]   = '0;
            cur_sign[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            check("rnd_valid", o_valid, m_full);
            if (m_full) begin
                check("rnd_pp", align_pp, m_pp);
                check("rnd_src", src_id, m_src);
            end
            for (int k = 0; k < N; k++) begin
                if (!pres[k] && $urandom_range(0, 1) == 1) begin
                    pres[k] = 1;
                    case ($urandom_range(0, 7))
                        0:       cur_pp[k] = '0;
                        1:       cur_pp[k] = '1;
                        default: cur_pp[k] = PP_W'($urandom);
                    endcase
                    cur_sign[k] = 1'($urandom_range(0, 1));
                end
                set_lane(k, pres[k], cur_pp[k], cur_sign[k]);
            end
            ready = ($urandom_range(0, 3) != 0);
            #1;
            grant = -1;
            if (!m_full || ready) begin
                for (int i = 0; i < N; i++) begin
                    int k2;
                    k2 = FIXED ? i : (m_ptr + i) % N;
                    if (grant < 0 && pres[k2]) grant = k2;
                end
            end
            exp_rdy = (grant >= 0) ? (N'(1) << grant) : '0;
            check("rnd_req_ready", req_ready, exp_rdy);
            if (grant >= 0) begin
                m_full      = 1;
                m_src       = grant;
                m_pp        = ref_align(cur_sign[grant], cur_pp[grant]);
                m_ptr       = (grant + 1) % N;
                pres[grant] = 0;
            end else if (ready) begin
                m_full = 0;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
